// File: rtl/act_unit_arbiter.sv
// Round-robin burst arbiter sharing one registered activation unit among NUM_REQ lanes,
// with id/last tagging and a credit-protected response FIFO. Optional counters: ACT_ARB_PERF_EN.
module act_unit_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int RSP_DEPTH   = 4,
    parameter int ACT_LATENCY = 1,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*3-1:0]          req_act_type,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [2:0]                    act_type,
    output logic                          act_valid_in,
    output logic [DATA_WIDTH-1:0]         act_data_in,
    input  logic [DATA_WIDTH-1:0]         act_data_out,
    input  logic                          act_valid_out,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ID_W-1:0]               rsp_id,
    output logic                          rsp_last,
    output logic                          busy
`ifdef ACT_ARB_PERF_EN
    ,
    output logic [31:0]                   perf_beats,
    output logic [31:0]                   perf_stall
`endif
);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int TAG_W = ID_W + 2;
    localparam int ENT_W = DATA_WIDTH + ID_W + 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [ID_W-1:0]       grant_q, grant_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [TAG_W-1:0]      tag_q [ACT_LATENCY];
    logic [TAG_W-1:0]      tag_d [ACT_LATENCY];
    logic [ENT_W-1:0]      mem_q [RSP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d, inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] data_hold_q, data_hold_d;
    logic [2:0]            type_hold_q, type_hold_d;

    logic [CNT_W:0]        occupancy;
    logic                  credit_ok, fire, push, pop, found;
    logic [ID_W-1:0]       pick, cand;
    logic [DATA_WIDTH-1:0] g_data;
    logic [2:0]            g_type;
    logic [ENT_W-1:0]      head;

    always_comb begin
        g_data = '0;
        g_type = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == grant_q) begin
                g_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                g_type = req_act_type[i*3 +: 3];
            end
        end

        // Credit counts FIFO entries plus beats still inside the unit, which cannot stall.
        occupancy = {1'b0, count_q} + {1'b0, inflight_q};
        credit_ok = occupancy < (CNT_W + 1)'(RSP_DEPTH);
        fire      = (state_q == ST_LOCKED) && req_valid[grant_q] && credit_ok;
        req_ready = '0;
        if (state_q == ST_LOCKED && credit_ok) req_ready[grant_q] = 1'b1;

        data_hold_d  = fire ? g_data : data_hold_q;
        type_hold_d  = fire ? g_type : type_hold_q;
        act_valid_in = fire;
        act_data_in  = data_hold_d;
        act_type     = type_hold_d;

        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        found    = 1'b0;
        pick     = '0;
        cand     = '0;
        if (state_q == ST_IDLE) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cand = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
                if (!found && req_valid[cand]) begin
                    found = 1'b1;
                    pick  = cand;
                end
            end
            if (found) begin
                state_d = ST_LOCKED;
                grant_d = pick;
            end
        end else if (fire && req_last[grant_q]) begin
            state_d  = ST_IDLE;
            rr_ptr_d = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);
        end

        tag_d[0] = {fire, grant_q, req_last[grant_q]};
        for (int k = 1; k < ACT_LATENCY; k++) tag_d[k] = tag_q[k-1];

        // Only tagged results are captured, so unit outputs left over from before reset are dropped.
        push      = act_valid_out && tag_q[ACT_LATENCY-1][TAG_W-1];
        rsp_valid = count_q != '0;
        pop       = rsp_valid && rsp_ready;
        head      = mem_q[rd_ptr_q];
        rsp_data  = rsp_valid ? head[ENT_W-1 -: DATA_WIDTH] : '0;
        rsp_id    = rsp_valid ? head[ID_W:1] : '0;
        rsp_last  = rsp_valid && head[0];

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        case ({fire, push})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase

        busy = (state_q == ST_LOCKED) || (inflight_q != '0) || rsp_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            inflight_q  <= '0;
            data_hold_q <= '0;
            type_hold_q <= '0;
            for (int k = 0; k < ACT_LATENCY; k++) tag_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            inflight_q  <= inflight_d;
            data_hold_q <= data_hold_d;
            type_hold_q <= type_hold_d;
            for (int k = 0; k < ACT_LATENCY; k++) tag_q[k] <= tag_d[k];
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {act_data_out, tag_q[ACT_LATENCY-1][ID_W:0]};
    end

    always @(posedge clk) begin
        if (!rst) assert (!(push && count_q == CNT_W'(RSP_DEPTH)));
    end

`ifdef ACT_ARB_PERF_EN
    logic [31:0] perf_beats_q, perf_beats_d, perf_stall_q, perf_stall_d;
    logic        stall;

    always_comb begin
        stall        = (state_q == ST_LOCKED) && req_valid[grant_q] && !credit_ok;
        perf_beats_d = (fire && perf_beats_q != '1) ? perf_beats_q + 32'd1 : perf_beats_q;
        perf_stall_d = (stall && perf_stall_q != '1) ? perf_stall_q + 32'd1 : perf_stall_q;
        perf_beats   = perf_beats_q;
        perf_stall   = perf_stall_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_beats_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_beats_q <= perf_beats_d;
            perf_stall_q <= perf_stall_d;
        end
    end
`endif
endmodule

// File: tb/tb_act_unit_arbiter.sv
// Bench for act_unit_arbiter: lane queues drive bursts, a transaction-level model predicts
// grants, credits and the ordered response stream; a 1-cycle unit model closes the loop.
module tb_act_unit_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DW      = 8;
    localparam int DEPTH   = 4;
    localparam int ID_W    = 2;
    localparam int ENT_W   = DW + ID_W + 1;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NUM_REQ-1:0]      req_valid = '0;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*DW-1:0]   req_data = '0;
    logic [NUM_REQ*3-1:0]    req_act_type = '0;
    logic [NUM_REQ-1:0]      req_last = '0;
    logic [2:0]              act_type;
    logic                    act_valid_in;
    logic [DW-1:0]           act_data_in;
    logic [DW-1:0]           act_data_out = '0;
    logic                    act_valid_out = 1'b0;
    logic                    rsp_valid;
    logic                    rsp_ready = 1'b0;
    logic [DW-1:0]           rsp_data;
    logic [ID_W-1:0]         rsp_id;
    logic                    rsp_last;
    logic                    busy;
`ifdef ACT_ARB_PERF_EN
    logic [31:0]             perf_beats, perf_stall;
`endif

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    act_unit_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .RSP_DEPTH(DEPTH), .ACT_LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .req_act_type(req_act_type), .req_last(req_last),
        .act_type(act_type), .act_valid_in(act_valid_in), .act_data_in(act_data_in),
        .act_data_out(act_data_out), .act_valid_out(act_valid_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_last(rsp_last), .busy(busy)
`ifdef ACT_ARB_PERF_EN
        , .perf_beats(perf_beats), .perf_stall(perf_stall)
`endif
    );

    function automatic logic [DW-1:0] act_fn(input logic [2:0] t, input logic [DW-1:0] x);
        case (t)
            3'd1:    act_fn = x[DW-1] ? '0 : x;
            3'd2:    act_fn = {x[DW-1], x[DW-1:1]};
            default: act_fn = x;
        endcase
    endfunction

    // activation unit: registered, cannot stall, knows nothing of reset
    always @(posedge clk) begin
        act_valid_out <= act_valid_in;
        act_data_out  <= act_fn(act_type, act_data_in);
    end

    // ---------------- lane queues (beat = {last, type, data}) ----------------
    logic [11:0] lane_mem [NUM_REQ][256];
    logic [7:0]  lane_rd [NUM_REQ];
    logic [7:0]  lane_wr [NUM_REQ];

    task automatic add_beat(input int lane, input logic [7:0] d, input logic [2:0] t, input logic l);
        lane_mem[lane][lane_wr[lane]] = {l, t, d};
        lane_wr[lane] = lane_wr[lane] + 8'd1;
    endtask

    task automatic add_rand_burst(input int lane, input int len);
        for (int b = 0; b < len; b++)
            add_beat(lane, 8'($urandom_range(255)), 3'($urandom_range(7)), b == len - 1);
    endtask

    // ---------------- model / scoreboard ----------------
    int  tests_run = 0, tests_failed = 0, cyc = 0;
    int  owner, ptr, pending, m_beats, m_stall;
    logic [DW-1:0]    last_d;
    logic [2:0]       last_t;
    logic [ENT_W-1:0] exp_q[$];
    int               exp_t_q[$];
    bit               post_rst;

    int          vld_pct = 100, rdy_pct = 100;
    logic [3:0]  gate_mask = '1;
    bit          rst_req = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        owner = -1; ptr = 0; pending = 0; m_beats = 0; m_stall = 0;
        last_d = '0; last_t = '0; post_rst = 1'b1;
        exp_q.delete(); exp_t_q.delete();
        for (int i = 0; i < NUM_REQ; i++) lane_rd[i] = lane_wr[i];
    endtask

    // one clock: drive inputs at negedge, then check/advance the model for that cycle
    task automatic step();
        logic [3:0]       vld, exp_rdy;
        logic [11:0]      beat;
        logic [ENT_W-1:0] ent;
        bit               credit, fire_m, exp_rv;
        @(negedge clk);
        cyc++;
        rst       = rst_req;
        rsp_ready = $urandom_range(99) < rdy_pct;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = ($urandom_range(99) < vld_pct) && gate_mask[i] && (lane_wr[i] != lane_rd[i]);
            beat = (lane_wr[i] != lane_rd[i]) ? lane_mem[i][lane_rd[i]] : 12'($urandom_range(4095));
            req_data[i*DW +: DW]  = beat[7:0];
            req_act_type[i*3 +: 3] = beat[10:8];
            req_last[i]           = beat[11];
        end
        #1;
        if (rst_req) begin
            model_reset();
            return;
        end
        if (post_rst) begin
            check_eq("rst_rsp_data", 32'(rsp_data), 0);
            check_eq("rst_rsp_id", 32'(rsp_id), 0);
            check_eq("rst_rsp_last", 32'(rsp_last), 0);
            post_rst = 1'b0;
        end
        vld     = req_valid;
        credit  = pending < DEPTH;
        exp_rdy = '0;
        if (owner >= 0 && credit) exp_rdy[owner] = 1'b1;
        check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
        fire_m = owner >= 0 && vld[owner] && credit;
        beat   = '0;
        if (fire_m) begin
            beat   = lane_mem[owner][lane_rd[owner]];
            last_d = beat[7:0];
            last_t = beat[10:8];
        end
        check_eq("act_valid_in", 32'(act_valid_in), 32'(fire_m));
        check_eq("act_data_in", 32'(act_data_in), 32'(last_d));
        check_eq("act_type", 32'(act_type), 32'(last_t));
        check_eq("busy", 32'(busy), 32'(owner >= 0 || pending > 0));
`ifdef ACT_ARB_PERF_EN
        check_eq("perf_beats", perf_beats, 32'(m_beats));
        check_eq("perf_stall", perf_stall, 32'(m_stall));
`endif
        exp_rv = exp_q.size() != 0 && exp_t_q[0] <= cyc;
        check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (exp_rv) begin
            check_eq("rsp_data", 32'(rsp_data), 32'(exp_q[0][ENT_W-1 -: DW]));
            check_eq("rsp_id", 32'(rsp_id), 32'(exp_q[0][ID_W:1]));
            check_eq("rsp_last", 32'(rsp_last), 32'(exp_q[0][0]));
            if (rsp_ready) begin
                void'(exp_q.pop_front());
                void'(exp_t_q.pop_front());
                pending--;
            end
        end
        if (owner >= 0 && vld[owner] && !credit) m_stall++;
        if (fire_m) begin
            ent = {act_fn(beat[10:8], beat[7:0]), 2'(owner), beat[11]};
            exp_q.push_back(ent);
            exp_t_q.push_back(cyc + 2);
            pending++;
            m_beats++;
            lane_rd[owner] = lane_rd[owner] + 8'd1;
            if (beat[11]) begin
                ptr   = (owner + 1) % NUM_REQ;
                owner = -1;
            end
        end else if (owner < 0) begin
            for (int k = 0; k < NUM_REQ; k++)
                if (owner < 0 && vld[(ptr + k) % NUM_REQ]) owner = (ptr + k) % NUM_REQ;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            lane_rd[i] = '0;
            lane_wr[i] = '0;
        end
        model_reset();
        rst_req = 1'b1;
        run(2);
        rst_req = 1'b0;

        // lane 2: ReLU burst 10, -5, 100
        add_beat(2, 8'd10, 3'd1, 1'b0);
        add_beat(2, 8'hFB, 3'd1, 1'b0);
        add_beat(2, 8'd100, 3'd1, 1'b1);
        run(10);

        // all lanes single-beat bursts, then lane 0 again
        for (int i = 0; i < NUM_REQ; i++) add_rand_burst(i, 1);
        run(10);
        add_rand_burst(0, 1);
        run(8);

        // lane 0 streams 8 beats into a stalled response port
        rdy_pct = 0;
        add_rand_burst(0, 8);
        run(12);
        rdy_pct = 100;
        run(20);

        // lane 1 with valid gaps while lane 3 waits
        add_rand_burst(1, 3);
        add_rand_burst(3, 2);
        gate_mask = 4'b1010; run(2);
        gate_mask = 4'b1000; run(2);
        gate_mask = 4'b1010; run(2);
        gate_mask = 4'b1111; run(10);

        // reset in the middle of a burst with two results held
        rdy_pct = 0;
        add_rand_burst(0, 4);
        run(3);
        gate_mask = 4'b1110; run(2);
        rst_req = 1'b1; run(1);
        rst_req = 1'b0; gate_mask = 4'b1111; rdy_pct = 100;
        add_rand_burst(2, 3);
        run(12);

        // randomized traffic with varying backpressure and one reset
        for (int seg = 0; seg < 15; seg++) begin
            case ($urandom_range(3))
                0: rdy_pct = 100;
                1: rdy_pct = 60;
                2: rdy_pct = 25;
                default: rdy_pct = 5;
            endcase
            vld_pct = $urandom_range(100, 50);
            for (int c = 0; c < 200; c++) begin
                for (int i = 0; i < NUM_REQ; i++)
                    if (lane_wr[i] == lane_rd[i] && $urandom_range(3) == 0)
                        add_rand_burst(i, $urandom_range(5, 1));
                rst_req = (seg == 7 && c == 100);
                step();
            end
        end
        rst_req = 1'b0;

        // drain: let every lane finish its burst, then empty the FIFO
        vld_pct = 100; rdy_pct = 100;
        run(120);
        check_eq("drain_exp_q", 32'(exp_q.size()), 0);
        check_eq("drain_busy", 32'(busy), 0);
        check_eq("drain_rsp_valid", 32'(rsp_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
